// File: rtl/mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared definitions for the data-side memory responder:
//   - controller state encoding (2 bits)
//   - access-size select codes as presented on mem_sel_i
//   - wait-state counter width and byte-lane count
//   - align_ok(): legality check of a size select against the low address bits
// -----------------------------------------------------------------------------
package mem_pkg;

   // Controller states
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACC  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Access-size select codes (right-aligned lane masks)
   localparam logic [3:0] SEL_BYTE = 4'b0001;
   localparam logic [3:0] SEL_HALF = 4'b0011;
   localparam logic [3:0] SEL_WORD = 4'b1111;

   // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15)
   localparam int CNT_W = 4;

   // Number of byte lanes in a 32-bit word
   localparam int NUM_LANES = 4;

   // Returns 1 when the size select is legal and naturally aligned to the lane.
   function automatic logic align_ok(input logic [3:0] sel, input logic [1:0] lane);
      logic ok;
      case (sel)
         SEL_BYTE: ok = 1'b1;
         SEL_HALF: ok = (lane[0] == 1'b0);
         SEL_WORD: ok = (lane == 2'b00);
         default:  ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/data_ram_bank.sv
// -----------------------------------------------------------------------------
// data_ram_bank
// Single-port 2^ADDR_WIDTH x 32 synchronous RAM with one write enable per byte
// lane and a registered read port. Array contents are not reset; only the read
// data register is cleared by reset.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset (read register only)
//   rd_en_i   in   capture mem[addr_i] into the read register on this edge
//   wr_be_i   in   per-lane write enables (bit i writes bits [8i+7:8i])
//   addr_i    in   word address
//   wdata_i   in   lane-positioned write data
//   rdata_o   out  registered read data (full word)
// -----------------------------------------------------------------------------
module data_ram_bank
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_en_i,
   input  logic [NUM_LANES-1:0]  wr_be_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rdata_q;

   // Byte-lane writes into the array (no reset so it maps onto block RAM).
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_LANES; i++) begin
         if (wr_be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
         end
      end
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= 32'h0000_0000;
      end else if (rd_en_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram_ctrl.sv
// -----------------------------------------------------------------------------
// data_ram_ctrl
// Data-side memory responder. Accepts one request from the memory stage,
// holds the pipeline with stall_req_o, inserts WAIT_CYCLES wait states, performs
// the array access, then pulses ack_o (and err_o for misaligned/illegal
// accesses) with right-aligned read data.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   mem_ce_i     in   request valid
//   mem_we_i     in   1 = write, 0 = read
//   mem_sel_i    in   size select: 0001 byte, 0011 half, 1111 word
//   mem_addr_i   in   byte address; [ADDR_WIDTH+1:2] word, [1:0] lane
//   mem_data_i   in   write data, right-aligned
//   mem_data_o   out  read data, right-aligned; valid while ack_o = 1
//   stall_req_o  out  pipeline hold request
//   ack_o        out  one-cycle completion pulse
//   err_o        out  one-cycle error pulse, coincident with ack_o
// -----------------------------------------------------------------------------
module data_ram_ctrl
   import mem_pkg::*;
#(
   parameter int ADDR_WIDTH  = 12,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_ce_i,
   input  logic        mem_we_i,
   input  logic [3:0]  mem_sel_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_data_i,
   output logic [31:0] mem_data_o,
   output logic        stall_req_o,
   output logic        ack_o,
   output logic        err_o
);

   localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

   // Controller state and latched request
   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [ADDR_WIDTH-1:0]  word_q;
   logic [1:0]             lane_q;
   logic                   we_q;
   logic [3:0]             sel_q;
   logic [31:0]            wdata_q;
   logic                   bad_q;
   logic                   ack_q;
   logic                   err_q;

   // Combinational helpers
   logic                   stall_s;
   logic [NUM_LANES-1:0]   lane_mask_s;
   logic [NUM_LANES-1:0]   bank_be_s;
   logic                   bank_re_s;
   logic [31:0]            bank_wdata_s;
   logic [31:0]            bank_rdata_s;
   logic [31:0]            rd_shift_s;
   logic [31:0]            rd_align_s;
   logic [31:0]            data_out_s;

   // Address bits above the RAM range alias and are deliberately dropped.
   logic                   unused_addr_s;
   assign unused_addr_s = ^mem_addr_i[31:ADDR_WIDTH+2];

   // Request FSM: latch on acceptance, count wait states, access, acknowledge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         word_q  <= '0;
         lane_q  <= 2'b00;
         we_q    <= 1'b0;
         sel_q   <= 4'b0000;
         wdata_q <= 32'h0000_0000;
         bad_q   <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ack_q <= 1'b0;
               err_q <= 1'b0;
               if (mem_ce_i) begin
                  word_q  <= mem_addr_i[ADDR_WIDTH+1:2];
                  lane_q  <= mem_addr_i[1:0];
                  we_q    <= mem_we_i;
                  sel_q   <= mem_sel_i;
                  wdata_q <= mem_data_i;
                  bad_q   <= ~align_ok(mem_sel_i, mem_addr_i[1:0]);
                  cnt_q   <= WAIT_INIT;
                  state_q <= (WAIT_CYCLES == 0) ? ST_ACC : ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               // Leave on the edge where the counter reaches 1; "<=" also
               // recovers from a corrupted zero count instead of wrapping.
               if (cnt_q <= 4'd1) begin
                  state_q <= ST_ACC;
               end
            end
            ST_ACC: begin
               // The array is accessed on this edge; ack/err register with it.
               ack_q   <= 1'b1;
               err_q   <= bad_q;
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               ack_q   <= 1'b0;
               err_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   // Stall request: mirrors mem_ce_i in IDLE so the pipeline freezes at once,
   // held through WAIT/ACC, released in DONE so the pipeline advances.
   always_comb begin
      stall_s = 1'b0;
      case (state_q)
         ST_IDLE: stall_s = mem_ce_i;
         ST_WAIT: stall_s = 1'b1;
         ST_ACC:  stall_s = 1'b1;
         ST_DONE: stall_s = 1'b0;
         default: stall_s = 1'b0;
      endcase
   end

   // Array controls: lane-shifted write enables and data during ACC. An
   // asserted rst on the ACC-exit edge suppresses the write.
   always_comb begin
      lane_mask_s  = sel_q << lane_q;
      bank_wdata_s = wdata_q << {lane_q, 3'b000};
      bank_be_s    = 4'b0000;
      bank_re_s    = 1'b0;
      if ((state_q == ST_ACC) && !bad_q && !rst) begin
         if (we_q) begin
            bank_be_s = lane_mask_s;
         end else begin
            bank_re_s = 1'b1;
         end
      end else begin
         bank_be_s = 4'b0000;
         bank_re_s = 1'b0;
      end
   end

   data_ram_bank #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .rd_en_i (bank_re_s),
      .wr_be_i (bank_be_s),
      .addr_i  (word_q),
      .wdata_i (bank_wdata_s),
      .rdata_o (bank_rdata_s)
   );

   // Read alignment: shift the addressed lane down to bit 0 and clear the
   // bits beyond the access size.
   always_comb begin
      rd_shift_s = bank_rdata_s >> {lane_q, 3'b000};
      rd_align_s = rd_shift_s;
      case (sel_q)
         SEL_BYTE: rd_align_s = {24'h00_0000, rd_shift_s[7:0]};
         SEL_HALF: rd_align_s = {16'h0000, rd_shift_s[15:0]};
         SEL_WORD: rd_align_s = rd_shift_s;
         default:  rd_align_s = 32'h0000_0000;
      endcase
   end

   // Output data is only driven during a successful read acknowledge.
   always_comb begin
      data_out_s = 32'h0000_0000;
      if (ack_q && !bad_q && !we_q) begin
         data_out_s = rd_align_s;
      end else begin
         data_out_s = 32'h0000_0000;
      end
   end

   assign mem_data_o  = data_out_s;
   assign stall_req_o = stall_s;
   assign ack_o       = ack_q;
   assign err_o       = err_q;

endmodule

// File: tb/tb_data_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_ram_ctrl
// Two responders share clock and reset: index 0 has WAIT_CYCLES=0, index 1 has
// WAIT_CYCLES=1. A byte-level memory model per instance predicts read data and
// error status for randomized traffic; directed scenarios use fixed values.
// -----------------------------------------------------------------------------
module tb_data_ram_ctrl;

   localparam int AW = 12;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ce   [2];
   logic        we   [2];
   logic [3:0]  sel  [2];
   logic [31:0] addr [2];
   logic [31:0] wd   [2];
   logic [31:0] rdo  [2];
   logic        stl  [2];
   logic        ackv [2];
   logic        errv [2];

   int vectors     = 0;
   int miscompares = 0;

   logic [31:0] mm0 [int];
   logic [31:0] mm1 [int];

   always #5 clk = ~clk;

   data_ram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut_w0 (
      .clk(clk), .rst(rst), .mem_ce_i(ce[0]), .mem_we_i(we[0]), .mem_sel_i(sel[0]),
      .mem_addr_i(addr[0]), .mem_data_i(wd[0]), .mem_data_o(rdo[0]),
      .stall_req_o(stl[0]), .ack_o(ackv[0]), .err_o(errv[0]));

   data_ram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_dut_w1 (
      .clk(clk), .rst(rst), .mem_ce_i(ce[1]), .mem_we_i(we[1]), .mem_sel_i(sel[1]),
      .mem_addr_i(addr[1]), .mem_data_i(wd[1]), .mem_data_o(rdo[1]),
      .stall_req_o(stl[1]), .ack_o(ackv[1]), .err_o(errv[1]));

   // One transaction on instance k. Called just after a rising edge with the
   // instance idle; returns just after the edge that leaves the ack cycle.
   // After cycle 0 the inputs are dropped/scrambled to show the latch holds.
   task automatic xact(input int k, input logic w, input logic [3:0] s,
                       input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] rdat, output logic rerr,
                       output int acyc, output bit stall_ok);
      ce[k] = 1'b1; we[k] = w; sel[k] = s; addr[k] = a; wd[k] = d;
      acyc = -1; stall_ok = 1'b1; rdat = 32'h0; rerr = 1'b0;
      for (int c = 0; c < 32 && acyc < 0; c++) begin
         @(negedge clk);
         if (ackv[k] === 1'b1) begin
            acyc = c; rdat = rdo[k]; rerr = errv[k];
            if (stl[k] !== 1'b0) stall_ok = 1'b0;
         end else begin
            if (stl[k] !== 1'b1) stall_ok = 1'b0;
         end
         @(posedge clk); #1;
         if (c == 0) begin
            ce[k] = 1'b0; we[k] = 1'($urandom); sel[k] = 4'($urandom);
            addr[k] = $urandom; wd[k] = $urandom;
         end
      end
   endtask

   // Reference model: byte-addressed memory behaviour from the access rules.
   task automatic model_apply(input int k, input logic w, input logic [3:0] s,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic [31:0] ed, output logic ee);
      int size, lane, idx;
      logic [31:0] word;
      case (s)
         4'b0001: size = 1;
         4'b0011: size = 2;
         4'b1111: size = 4;
         default: size = 0;
      endcase
      lane = int'(a % 32'd4);
      idx  = int'((a / 32'd4) % (32'd1 << AW));
      ee   = (size == 0) || ((lane % size) != 0);
      ed   = 32'h0;
      word = 32'hxxxx_xxxx;
      if (k == 0 && mm0.exists(idx)) word = mm0[idx];
      if (k == 1 && mm1.exists(idx)) word = mm1[idx];
      if (!ee) begin
         for (int b = 0; b < size; b++) begin
            if (w) word[8*(lane+b) +: 8] = d[8*b +: 8];
            else   ed[8*b +: 8] = word[8*(lane+b) +: 8];
         end
         if (w && k == 0) mm0[idx] = word;
         if (w && k == 1) mm1[idx] = word;
      end
   endtask

   task automatic test_reset();
      for (int k = 0; k < 2; k++) begin
         ce[k] = 1'b0; we[k] = 1'b0; sel[k] = 4'h0; addr[k] = 32'h0; wd[k] = 32'h0;
      end
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         vectors++; if (ackv[k] !== 1'b0) begin miscompares++; $display("FAIL reset_ack[%0d]: got %b want 0", k, ackv[k]); end
         vectors++; if (errv[k] !== 1'b0) begin miscompares++; $display("FAIL reset_err[%0d]: got %b want 0", k, errv[k]); end
         vectors++; if (rdo[k] !== 32'h0) begin miscompares++; $display("FAIL reset_data[%0d]: got %h want 0", k, rdo[k]); end
         vectors++; if (stl[k] !== 1'b0) begin miscompares++; $display("FAIL reset_stall[%0d]: got %b want 0", k, stl[k]); end
      end
      ce[1] = 1'b1; #1;
      vectors++; if (stl[1] !== 1'b1) begin miscompares++; $display("FAIL reset_stall_follow: got %b want 1", stl[1]); end
      ce[1] = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_word_rw();
      logic [31:0] rd; logic er; int ac; bit so;
      xact(1, 1'b1, 4'b1111, 32'h100, 32'h1122_3344, rd, er, ac, so);
      vectors++; if (ac !== 3 || er !== 1'b0 || !so) begin miscompares++; $display("FAIL sw_0x100: ack_cycle %0d err %b stall_ok %0d want 3 0 1", ac, er, so); end
      xact(1, 1'b0, 4'b1111, 32'h100, 32'h0, rd, er, ac, so);
      vectors++; if (ac !== 3 || !so) begin miscompares++; $display("FAIL lw_timing: ack_cycle %0d stall_ok %0d want 3 1", ac, so); end
      vectors++; if (rd !== 32'h1122_3344) begin miscompares++; $display("FAIL lw_data: got %h want 11223344", rd); end
   endtask

   task automatic test_byte_half();
      logic [31:0] rd; logic er; int ac; bit so;
      xact(1, 1'b1, 4'b0001, 32'h101, 32'h0000_00AB, rd, er, ac, so);
      xact(1, 1'b0, 4'b1111, 32'h100, 32'h0, rd, er, ac, so);
      vectors++; if (rd !== 32'h1122_AB44) begin miscompares++; $display("FAIL sb_word: got %h want 1122ab44", rd); end
      xact(1, 1'b0, 4'b0001, 32'h101, 32'h0, rd, er, ac, so);
      vectors++; if (rd !== 32'h0000_00AB || er !== 1'b0) begin miscompares++; $display("FAIL lb_0x101: got %h err %b want 000000ab 0", rd, er); end
      xact(1, 1'b1, 4'b0011, 32'h102, 32'h0000_BEEF, rd, er, ac, so);
      xact(1, 1'b0, 4'b0011, 32'h102, 32'h0, rd, er, ac, so);
      vectors++; if (rd !== 32'h0000_BEEF) begin miscompares++; $display("FAIL lh_0x102: got %h want 0000beef", rd); end
      xact(1, 1'b0, 4'b1111, 32'h100, 32'h0, rd, er, ac, so);
      vectors++; if (rd !== 32'hBEEF_AB44) begin miscompares++; $display("FAIL sh_word: got %h want beefab44", rd); end
   endtask

   task automatic test_misaligned();
      logic [31:0] rd; logic er; int ac; bit so;
      xact(1, 1'b1, 4'b1111, 32'h103, 32'hFFFF_FFFF, rd, er, ac, so);
      vectors++; if (er !== 1'b1 || ac !== 3 || !so) begin miscompares++; $display("FAIL sw_0x103: err %b ack_cycle %0d stall_ok %0d want 1 3 1", er, ac, so); end
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL sw_0x103_data: got %h want 0", rd); end
      xact(1, 1'b0, 4'b0011, 32'h101, 32'h0, rd, er, ac, so);
      vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL lh_0x101: err %b data %h want 1 0", er, rd); end
      xact(1, 1'b0, 4'b0101, 32'h100, 32'h0, rd, er, ac, so);
      vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL bad_sel: err %b data %h want 1 0", er, rd); end
      xact(1, 1'b0, 4'b1111, 32'h100, 32'h0, rd, er, ac, so);
      vectors++; if (rd !== 32'hBEEF_AB44 || er !== 1'b0) begin miscompares++; $display("FAIL after_err_word: got %h err %b want beefab44 0", rd, er); end
   endtask

   task automatic test_back_to_back();
      int cyc[$]; logic [31:0] dat[$];
      ce[1] = 1'b1; we[1] = 1'b0; sel[1] = 4'b1111; addr[1] = 32'h100; wd[1] = 32'h0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (ackv[1] === 1'b1) begin cyc.push_back(c); dat.push_back(rdo[1]); end
         @(posedge clk); #1;
      end
      ce[1] = 1'b0;
      @(posedge clk); #1;
      vectors++; if (cyc.size() != 3) begin miscompares++; $display("FAIL b2b_count: got %0d acks want 3", cyc.size()); end
      foreach (cyc[i]) begin
         vectors++; if (cyc[i] != 3 + 4*i || dat[i] !== 32'hBEEF_AB44) begin
            miscompares++; $display("FAIL b2b_ack%0d: cycle %0d data %h want %0d beefab44", i, cyc[i], dat[i], 3 + 4*i); end
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int ac; bit so; bit seen;
      xact(1, 1'b1, 4'b1111, 32'h300, 32'h5566_7788, rd, er, ac, so);
      ce[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'b1111; addr[1] = 32'h300; wd[1] = 32'hDEAD_BEEF;
      @(posedge clk); #1;            // cycle 1: WAIT
      ce[1] = 1'b0;
      @(posedge clk); #1;            // cycle 2: ACC
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (ackv[1] !== 1'b0 || stl[1] !== 1'b0) seen = 1'b1;
         @(posedge clk); #1;
      end
      vectors++; if (seen) begin miscompares++; $display("FAIL rst_mid_idle: got ack/stall activity want none"); end
      xact(1, 1'b0, 4'b1111, 32'h300, 32'h0, rd, er, ac, so);
      vectors++; if (rd !== 32'h5566_7788 || ac !== 3) begin miscompares++; $display("FAIL rst_mid_data: got %h cycle %0d want 55667788 3", rd, ac); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] rd; logic er; int ac; bit so;
      xact(0, 1'b1, 4'b1111, 32'h100, 32'hCAFE_F00D, rd, er, ac, so);
      vectors++; if (ac !== 2 || !so) begin miscompares++; $display("FAIL w0_sw: ack_cycle %0d stall_ok %0d want 2 1", ac, so); end
      xact(0, 1'b0, 4'b1111, 32'h100, 32'h0, rd, er, ac, so);
      vectors++; if (ac !== 2 || rd !== 32'hCAFE_F00D || !so) begin miscompares++; $display("FAIL w0_lw: cycle %0d data %h want 2 cafef00d", ac, rd); end
      xact(0, 1'b0, 4'b1111, 32'hFFFF_C100, 32'h0, rd, er, ac, so);
      vectors++; if (rd !== 32'hCAFE_F00D) begin miscompares++; $display("FAIL w0_alias: got %h want cafef00d", rd); end
   endtask

   task automatic test_random(input int k);
      logic [31:0] rd, ed, a, d; logic er, ee, w; int ac; bit so; logic [3:0] s;
      int lat;
      lat = (k == 0) ? 2 : 3;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         model_apply(k, 1'b1, 4'b1111, 32'h200 + 32'(4*i), d, ed, ee);
         xact(k, 1'b1, 4'b1111, 32'h200 + 32'(4*i), d, rd, er, ac, so);
         vectors++; if (ac != lat || er !== 1'b0) begin miscompares++; $display("FAIL rnd_init[%0d] %0d: cycle %0d err %b", k, i, ac, er); end
      end
      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 4))
            0: s = 4'b0001;
            1: s = 4'b0011;
            3: s = 4'($urandom);
            default: s = 4'b1111;
         endcase
         w = 1'($urandom_range(0, 1));
         a = 32'h200 + 32'(4*$urandom_range(0, 15)) + 32'($urandom_range(0, 3));
         a[31:AW+2] = 18'($urandom);
         d = $urandom;
         model_apply(k, w, s, a, d, ed, ee);
         xact(k, w, s, a, d, rd, er, ac, so);
         vectors++;
         if (ac != lat || !so || er !== ee || ((!w || ee) && rd !== ed)) begin
            miscompares++;
            $display("FAIL rnd[%0d] %0d we=%b sel=%b addr=%h: cycle %0d stall_ok %0d err %b data %h want cycle %0d err %b data %h",
                     k, i, w, s, a, ac, so, er, rd, lat, ee, ed);
         end
      end
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_byte_half();
      test_misaligned();
      test_back_to_back();
      test_reset_mid();
      test_zero_wait();
      test_random(0);
      test_random(1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_ram_ctrl.md
# data_ram_ctrl

Data-side memory responder for the five-stage core. It sits on the far side of the memory-stage request interface (address, write enable, size select, write data, chip enable) and services each request from a single-port byte-lane RAM with a configurable number of wait states. It returns read data right-aligned to bit 0 and holds the pipeline with a stall request until each access completes. Misaligned accesses are rejected with an error pulse.

## Interface
- ADDR_WIDTH, 12: word-address bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 1: extra wait states before the array access; range 0..15.
- clk  in  1: rising-edge clock.
- rst  in  1: reset, synchronous, active-high.
- mem_ce_i  in  1: request valid (chip enable).
- mem_we_i  in  1: 1 = write, 0 = read.
- mem_sel_i  in  4: access size. 0001 = byte, 0011 = halfword, 1111 = word; any other value is an error.
- mem_addr_i  in  32: byte address. Bits [ADDR_WIDTH+1:2] select the word, bits [1:0] select the lane.
- mem_data_i  in  32: write data, right-aligned at bit 0.
- mem_data_o  out  32: read data, right-aligned at bit 0; valid only while ack_o=1.
- stall_req_o  out  1: pipeline hold request.
- ack_o  out  1: one-cycle completion pulse.
- err_o  out  1: one-cycle misaligned/illegal pulse, coincident with ack_o.

## Operation
- States: IDLE, WAIT, ACC, DONE.
- IDLE:
  - stall_req_o = mem_ce_i (combinational), so the pipeline freezes in the cycle the request appears.
  - On mem_ce_i=1, latch addr, we, sel and data, and load the counter with WAIT_CYCLES.
  - Next state is WAIT, or ACC if WAIT_CYCLES=0.
- WAIT: stall_req_o=1; the counter decrements each cycle; move to ACC on the edge where the counter reaches 1.
- ACC: stall_req_o=1; the array read or write is performed on the clock edge leaving ACC; next state DONE.
- DONE: stall_req_o=0 and ack_o=1; mem_data_o shows registered read data; the pipeline advances on this edge; next state IDLE.
- Lane mask = mem_sel << addr[1:0].
  - Write: data << 8*addr[1:0], written under the lane mask.
  - Read: full word >> 8*addr[1:0], with upper bits beyond the access size zeroed (byte reads zero bits [31:8], halfword reads zero bits [31:16]).
- Error when:
  - halfword with addr[0]=1,
  - word with addr[1:0]≠0,
  - illegal sel value.
- On error: no array write, mem_data_o=0 and err_o=1 in DONE. Timing is identical to a legal access.
- Latched request is authoritative. Input changes or mem_ce_i deassertion after acceptance are ignored, and the transaction completes.
- Address bits above ADDR_WIDTH+1 are ignored (aliasing).

## Timing
- Request accepted in cycle 0. Read data and ack_o appear in cycle WAIT_CYCLES+2.
- stall_req_o is high in cycles 0..WAIT_CYCLES+1.
- Back-to-back requests: throughput is one access per WAIT_CYCLES+3 cycles.
- No new request is accepted in DONE; the next request is seen in IDLE the following cycle.
- Reset values: state IDLE, counter 0, stall_req_o follows mem_ce_i, ack_o=0, err_o=0, mem_data_o=0.
- RAM contents are not reset.
- Reset mid-operation: return to IDLE with no pending write.
  - Reset asserted on the ACC-exit edge takes priority: the write is not committed.
  - Any write committed on an earlier edge stays.

## Structure
- Shared package mem_pkg holds:
  - state encoding (2 bits),
  - SEL_BYTE/SEL_HALF/SEL_WORD constants,
  - an align-check function.
- Sub-module data_ram_bank: 2^ADDR_WIDTH × 32 synchronous RAM with 4 byte-lane write enables and a registered read port.
- The controller FSM, counter, alignment logic and shifters live in data_ram_ctrl.

## Test plan
- SW 0x11223344 at 0x100, then LW 0x100 with WAIT_CYCLES=1:
  - ack in cycle 3, mem_data_o=0x11223344,
  - stall_req high for cycles 0-2.
- SB 0xAB at 0x101 over 0x11223344, then word read:
  - read returns 0x1122AB44,
  - a byte read at 0x101 returns 0x000000AB.
- SH 0xBEEF at 0x102, then halfword read at 0x102: returns 0x0000BEEF; the word reads 0xBEEFxxxx with the low half unchanged.
- Word write at 0x103:
  - err_o=1 and ack_o=1 in cycle 3,
  - memory unchanged,
  - mem_data_o=0.
- WAIT_CYCLES=0:
  - read of 0x100 acks in cycle 2,
  - deasserting mem_ce_i in cycle 1 still completes with ack.
- Write issued, rst pulsed in the ACC cycle:
  - state returns to IDLE,
  - no ack,
  - subsequent read shows the old data.
